// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with almost flags, sticky error flags and a peak-occupancy watermark.
// Read data is registered one cycle after an accepted read; a write while full is refused unless it is paired with a read.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic [AW:0]      use_dw,
  output logic             full_n,
  output logic             empty_n,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [AW:0]      peak_dw
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] LP_AE   = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      r_peak;
  logic [WIDTH-1:0] r_data_out;
  logic             r_full_n;
  logic             r_empty_n;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [AW:0]      w_count_nxt;

  // A write while full is only accepted when a read frees the slot on the same edge.
  assign w_wr_acc = write & (r_full_n | read);
  assign w_rd_acc = read & r_empty_n;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !clear) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_peak         <= '0;
      r_data_out     <= '0;
      r_full_n       <= 1'b1;
      r_empty_n      <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else if (clear) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_peak         <= '0;
      r_full_n       <= 1'b1;
      r_empty_n      <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_count        <= w_count_nxt;
      r_full_n       <= (w_count_nxt != LP_FULL);
      r_empty_n      <= (w_count_nxt != '0);
      r_almost_full  <= (w_count_nxt >= LP_AF);
      r_almost_empty <= (w_count_nxt <= LP_AE);
      r_overflow     <= r_overflow | (write & ~r_full_n & ~read);
      r_underflow    <= r_underflow | (read & ~r_empty_n);
      r_peak         <= (w_count_nxt > r_peak) ? w_count_nxt : r_peak;
    end
  end

  assign data_out     = r_data_out;
  assign use_dw       = r_count;
  assign full_n       = r_full_n;
  assign empty_n      = r_empty_n;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign peak_dw      = r_peak;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: default 32x8 FIFO plus a 4x16 instance with tight almost levels.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_clear = 1'b0, a_write = 1'b0, a_read = 1'b0;
  logic [7:0]  a_din = '0;
  logic [7:0]  a_dout;
  logic [5:0]  a_use, a_peak;
  logic        a_full_n, a_empty_n, a_af, a_ae, a_ovf, a_unf;

  logic        b_clear = 1'b0, b_write = 1'b0, b_read = 1'b0;
  logic [15:0] b_din = '0;
  logic [15:0] b_dout;
  logic [2:0]  b_use, b_peak;
  logic        b_full_n, b_empty_n, b_af, b_ae, b_ovf, b_unf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_param u_a (
    .clk(clk), .rst(rst), .clear(a_clear), .write(a_write), .data_in(a_din), .read(a_read),
    .data_out(a_dout), .use_dw(a_use), .full_n(a_full_n), .empty_n(a_empty_n),
    .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf), .underflow(a_unf), .peak_dw(a_peak)
  );

  fifo_sync_param #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(0)) u_b (
    .clk(clk), .rst(rst), .clear(b_clear), .write(b_write), .data_in(b_din), .read(b_read),
    .data_out(b_dout), .use_dw(b_use), .full_n(b_full_n), .empty_n(b_empty_n),
    .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf), .peak_dw(b_peak)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    #1;
    chk("rst_use", int'(a_use), 0);
    chk("rst_empty_n", int'(a_empty_n), 0);
    chk("rst_full_n", int'(a_full_n), 1);
    chk("rst_ae", int'(a_ae), 1);
    chk("rst_af", int'(a_af), 0);
    chk("rst_dout", int'(a_dout), 0);

    // Load a few words, then pulse reset between edges.
    a_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'hC0 + i);
      step();
    end
    a_write = 1'b0;
    chk("pre_rst_use", int'(a_use), 3);
    #3 rst = 1'b1;
    #1;
    chk("async_use", int'(a_use), 0);
    chk("async_empty_n", int'(a_empty_n), 0);
    chk("async_full_n", int'(a_full_n), 1);
    chk("async_ae", int'(a_ae), 1);
    chk("async_ovf", int'(a_ovf), 0);
    chk("async_peak", int'(a_peak), 0);
    #1 rst = 1'b0;

    // Fill 0x00..0x1F.
    a_write = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_din = 8'(i);
      step();
      chk("fill_use", int'(a_use), i + 1);
      chk("fill_af", int'(a_af), (i + 1 >= 28) ? 1 : 0);
      chk("fill_full_n", int'(a_full_n), (i + 1 == 32) ? 0 : 1);
      chk("fill_ae", int'(a_ae), (i + 1 <= 4) ? 1 : 0);
    end
    a_din = 8'hEE;
    step();
    a_write = 1'b0;
    chk("ovf_set", int'(a_ovf), 1);
    chk("ovf_use", int'(a_use), 32);
    chk("ovf_unf", int'(a_unf), 0);

    a_read = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("drain_dout", int'(a_dout), i);
      chk("drain_use", int'(a_use), 31 - i);
    end
    a_read = 1'b0;
    chk("drain_empty_n", int'(a_empty_n), 0);
    chk("drain_peak", int'(a_peak), 32);
    step();
    chk("dout_hold", int'(a_dout), 8'h1F);

    // Empty read, then read+write while empty.
    a_read = 1'b1;
    step();
    chk("unf_set", int'(a_unf), 1);
    chk("unf_dout", int'(a_dout), 8'h1F);
    chk("unf_use", int'(a_use), 0);
    a_write = 1'b1;
    a_din = 8'hA5;
    step();
    a_write = 1'b0;
    chk("erw_use", int'(a_use), 1);
    chk("erw_dout", int'(a_dout), 8'h1F);
    step();
    a_read = 1'b0;
    chk("erw_rd", int'(a_dout), 8'hA5);
    chk("erw_use0", int'(a_use), 0);

    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    chk("clr_ovf", int'(a_ovf), 0);
    chk("clr_unf", int'(a_unf), 0);
    chk("clr_peak", int'(a_peak), 0);
    chk("clr_dout", int'(a_dout), 8'hA5);

    // Full read+write: oldest word out, new word joins the tail.
    a_write = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_din = 8'(8'h40 + i);
      step();
    end
    chk("full2_full_n", int'(a_full_n), 0);
    a_read = 1'b1;
    a_din = 8'h77;
    step();
    a_write = 1'b0;
    chk("frw_use", int'(a_use), 32);
    chk("frw_ovf", int'(a_ovf), 0);
    chk("frw_dout", int'(a_dout), 8'h40);
    for (int i = 0; i < 32; i++) begin
      step();
      chk("frw_drain", int'(a_dout), (i < 31) ? (8'h41 + i) : 8'h77);
    end
    a_read = 1'b0;
    chk("frw_use0", int'(a_use), 0);

    // Wrap-around at occupancy 3.
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    a_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h10 + i);
      step();
    end
    a_read = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a_din = 8'(8'h13 + i);
      step();
      chk("wrap_dout", int'(a_dout), 8'h10 + i);
      chk("wrap_use", int'(a_use), 3);
    end
    a_read = 1'b0;
    chk("wrap_peak", int'(a_peak), 3);

    // Clear beats write+read at occupancy 10.
    for (int i = 0; i < 7; i++) begin
      a_din = 8'(8'h80 + i);
      step();
    end
    chk("pre_clr_use", int'(a_use), 10);
    a_read = 1'b1;
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    a_read = 1'b0;
    a_write = 1'b0;
    chk("clr2_use", int'(a_use), 0);
    chk("clr2_empty_n", int'(a_empty_n), 0);
    chk("clr2_ae", int'(a_ae), 1);
    chk("clr2_af", int'(a_af), 0);
    chk("clr2_peak", int'(a_peak), 0);
    chk("clr2_dout", int'(a_dout), 8'h73);
    a_write = 1'b1;
    a_din = 8'h99;
    step();
    a_write = 1'b0;
    a_read = 1'b1;
    step();
    a_read = 1'b0;
    chk("post_clr_rd", int'(a_dout), 8'h99);

    // 4x16 instance, AF_LEVEL=3, AE_LEVEL=0.
    chk("b_rst_use", int'(b_use), 0);
    chk("b_rst_ae", int'(b_ae), 1);
    b_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_din = 16'(16'hB000 + i);
      step();
      chk("b_fill_use", int'(b_use), i + 1);
      chk("b_fill_af", int'(b_af), (i + 1 >= 3) ? 1 : 0);
      chk("b_fill_ae", int'(b_ae), 0);
      chk("b_fill_full_n", int'(b_full_n), (i == 3) ? 0 : 1);
    end
    b_din = 16'hDEAD;
    step();
    b_write = 1'b0;
    chk("b_ovf", int'(b_ovf), 1);
    chk("b_ovf_use", int'(b_use), 4);
    b_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b_drain", int'(b_dout), 16'hB000 + i);
      chk("b_drain_ae", int'(b_ae), (i == 3) ? 1 : 0);
    end
    b_read = 1'b0;
    chk("b_empty_n", int'(b_empty_n), 0);
    chk("b_peak", int'(b_peak), 4);
    chk("b_unf", int'(b_unf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO core. It is the next generation of the 32x8 FIFO core that sits behind the pad ring.
- It generalises width and depth and adds programmable almost-full and almost-empty flags.
- It adds sticky overflow/underflow error flags, a peak-occupancy watermark and a synchronous flush.
- It drops into the pad-ring top in place of the fixed core. Status outputs go to output pads; DFT scan insertion is handled at synthesis.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 32, number of entries. Power of two, >=4.
- AW, $clog2(DEPTH), pointer width. Derived; do not override.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL (1..DEPTH-1).
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-2).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush. Empties the FIFO and clears sticky flags and the watermark.
- write  input  1  write request.
- data_in  input  WIDTH  write data, sampled when a write is accepted.
- read  input  1  read request.
- data_out  output  WIDTH  registered read data.
- use_dw  output  AW+1  current occupancy, 0..DEPTH.
- full_n  output  1  low when count==DEPTH.
- empty_n  output  1  low when count==0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- overflow  output  1  sticky: a write was attempted while full and not accepted.
- underflow  output  1  sticky: a read was attempted while empty and not accepted.
- peak_dw  output  AW+1  maximum use_dw reached since the last rst/clear.

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=rd_ptr=0, count=0, data_out=0, full_n=1, empty_n=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, peak_dw=0. Storage array is not reset.
- Accept rules, evaluated on the same edge:
  - wr_acc = write & (full_n | read).
  - rd_acc = read & empty_n.
  - When full, a simultaneous read+write is accepted and count is unchanged.
  - When empty, read+write accepts the write only; the read is not accepted and sets underflow.
- Count update:
  - +1 on wr_acc & ~rd_acc.
  - -1 on rd_acc & ~wr_acc.
  - Otherwise unchanged.
  - use_dw, full_n, empty_n, almost_full and almost_empty are all registered and reflect the new count in the cycle after the edge.
- Pointers: AW bits, increment on accept, wrap DEPTH-1 -> 0 naturally.
- Read latency: on rd_acc, data_out <= mem[rd_ptr] at the same edge, so valid 1 cycle after read is sampled high.
  - data_out holds its value when no read is accepted.
  - No fall-through: a word written while empty is readable at the earliest on the next cycle.
- Error flags:
  - overflow sets on write & ~full_n & ~read.
  - underflow sets on read & ~empty_n.
  - Both stay set until rst or clear. A rejected access changes no pointer or count.
- Watermark: peak_dw <= max(peak_dw, next count) every cycle.
- clear (synchronous):
  - Has priority over write/read in the same cycle; both are ignored.
  - Next state equals reset state except data_out, which holds its value.
- Reset mid-operation: all state returns to reset values immediately. Contents are lost logically (pointers reset).
- Must use no latches and no combinational path from inputs to outputs.

Test Plan:
- Reset/defaults: assert rst asynchronously between edges -> outputs update immediately: use_dw=0, empty_n=0, full_n=1, almost_empty=1, overflow=0, peak_dw=0.
- Fill/drain with defaults (WIDTH=8, DEPTH=32), writing 0x00..0x1F:
  - almost_full rises when use_dw=28; full_n=0 at 32.
  - A 33rd write sets overflow, use_dw stays 32.
  - Reading 32 times returns 0x00..0x1F in order, each 1 cycle after its read.
  - empty_n=0 after the last read; peak_dw=32.
- Empty read/write, with the FIFO empty:
  - read alone -> underflow=1, data_out unchanged.
  - read+write with 0xA5 -> use_dw=1, and the next read returns 0xA5.
- Full read+write: at use_dw=32, write 0x77 with read -> use_dw stays 32, overflow stays 0, oldest word appears on data_out, and 0x77 emerges last after a full drain.
- Wrap-around: cycle 100 interleaved write/read pairs at occupancy 3 -> no data mismatch across pointer wrap; use_dw stays 3; peak_dw=3.
- Flush/parametrisation:
  - clear with write+read high at use_dw=10 -> use_dw=0, flags cleared, peak_dw=0, data_out held.
  - Rerun the fill/drain scenario with WIDTH=16, DEPTH=4, AF_LEVEL=3, AE_LEVEL=0.
